// File: rtl/rng_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rng_draw_arbiter
// Brief    : Round-robin arbiter sharing one step-enabled 10-bit LFSR; returns
//            uniform 0-9 digits via rejection sampling.
// Revision : 1.0 - initial release
// ============================================================================
module rng_draw_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IDW       = 2,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] ack_o,
  output logic             rsp_valid_o,
  output logic [3:0]       rsp_value_o,
  output logic             rsp_err_o,
  output logic [IDW-1:0]   rsp_id_o,
  output logic             busy_o,
  input  logic [9:0]       rng_raw_i,
  output logic             rng_step_o,
  output logic [15:0]      draw_count_o
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]  C_LAST_TRY = TW'(MAX_TRIES - 1);
  localparam logic [IDW-1:0] C_LAST_ID  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [3:0]      val_q, val_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  int              w_idx;
  logic [9:0]      w_raw_m1;
  logic [3:0]      w_digit;

  // Rotating priority search: first set request at or above ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(ptr_q) + k) % N_REQ;
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(w_idx);
      end
    end
  end

  // Raw values 1..1000 fold onto 0..9 with exactly 100 states per digit.
  assign w_raw_m1 = rng_raw_i - 10'd1;
  assign w_digit  = 4'(w_raw_m1 % 10'd10);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    tries_d = tries_q;
    val_d   = val_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          gnt_d   = w_win;
          tries_d = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (rng_raw_i == 10'd0) begin
          val_d   = 4'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (rng_raw_i <= 10'd1000) begin
          val_d   = w_digit;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tries_q == C_LAST_TRY) begin
          val_d   = 4'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      S_RESP: begin
        ptr_d   = (gnt_q == C_LAST_ID) ? '0 : gnt_q + IDW'(1);
        cnt_d   = cnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      tries_q <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      tries_q <= tries_d;
      val_q   <= val_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_ack
      assign ack_o[g] = (state_q == S_RESP) && (gnt_q == IDW'(g));
    end
  endgenerate

  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_value_o  = val_q;
  assign rsp_err_o    = err_q;
  assign rsp_id_o     = gnt_q;
  assign busy_o       = (state_q != S_IDLE);
  assign rng_step_o   = (state_q == S_SAMPLE);
  assign draw_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_draw_arbiter
// Brief    : Vector table, corner sequences and randomized draws for
//            rng_draw_arbiter against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_draw_arbiter;

  localparam int MAXT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  ack;
  logic        rsp_valid;
  logic [3:0]  rsp_value;
  logic        rsp_err;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [9:0]  rng_raw = '0;
  logic        rng_step;
  logic [15:0] draw_count;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  int dc_m    = 0;
  logic [9:0] raws [MAXT];

  always #5 clk = ~clk;

  rng_draw_arbiter #(.N_REQ(4), .IDW(2), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .ack_o(ack),
    .rsp_valid_o(rsp_valid), .rsp_value_o(rsp_value), .rsp_err_o(rsp_err),
    .rsp_id_o(rsp_id), .busy_o(busy), .rng_raw_i(rng_raw),
    .rng_step_o(rng_step), .draw_count_o(draw_count)
  );

  typedef struct packed {
    logic [3:0] rq;
    logic [4:0] nrep;
    logic [9:0] rep;
    logic [9:0] tail;
    logic [1:0] id;
    logic [3:0] val;
    logic       err;
    logic [4:0] steps;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++)
      if (rq[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Drive one draw; the bench plays the LFSR, advancing after each stepped edge.
  task automatic run_draw(input string nm, input logic [3:0] rq, input int e_id,
                          input int e_val, input int e_err, input int e_steps);
    int  steps = 0;
    bit  got   = 0;
    bit  s;
    @(negedge clk);
    req     = rq;
    rng_raw = raws[0];
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        check({nm, " ack"},   32'(ack),       32'(1 << e_id));
        check({nm, " id"},    32'(rsp_id),    32'(e_id));
        check({nm, " value"}, 32'(rsp_value), 32'(e_val));
        check({nm, " err"},   32'(rsp_err),   32'(e_err));
        check({nm, " steps"}, 32'(steps),     32'(e_steps));
        check({nm, " busy"},  32'(busy),      32'd1);
        req = '0;
      end else begin
        s = rng_step;
        @(posedge clk);
        #1;
        if (s) begin
          steps++;
          rng_raw = raws[(steps > MAXT-1) ? MAXT-1 : steps];
        end
      end
    end
    if (!got) check({nm, " ack timeout"}, 32'd0, 32'd1);
    ptr_m = (e_id + 1) % 4;
    dc_m  = (dc_m + 1) % 65536;
    @(negedge clk);
    check({nm, " count"},     32'(draw_count), 32'(dc_m));
    check({nm, " idle ack"},  32'({ack, rsp_valid, busy}), 32'd0);
    check({nm, " hold val"},  32'(rsp_value), 32'(e_val));
  endtask

  task automatic fill(input int nrep, input logic [9:0] rep, input logic [9:0] tail);
    for (int i = 0; i < MAXT; i++) raws[i] = (i < nrep) ? rep : tail;
  endtask

  vec_t tbl [13];

  initial begin
    int e_val, e_err, e_steps, e_id;
    logic [3:0] rq;
    bit done;

    tbl[0]  = '{4'b0001, 5'd0,  10'd0,    10'd535,  2'd0, 4'd4, 1'b0, 5'd1};
    tbl[1]  = '{4'b0010, 5'd2,  10'd1010, 10'd1000, 2'd1, 4'd9, 1'b0, 5'd3};
    tbl[2]  = '{4'b1111, 5'd0,  10'd0,    10'd11,   2'd2, 4'd0, 1'b0, 5'd1};
    tbl[3]  = '{4'b1111, 5'd0,  10'd0,    10'd11,   2'd3, 4'd0, 1'b0, 5'd1};
    tbl[4]  = '{4'b1111, 5'd0,  10'd0,    10'd11,   2'd0, 4'd0, 1'b0, 5'd1};
    tbl[5]  = '{4'b1111, 5'd0,  10'd0,    10'd11,   2'd1, 4'd0, 1'b0, 5'd1};
    tbl[6]  = '{4'b1111, 5'd0,  10'd0,    10'd11,   2'd2, 4'd0, 1'b0, 5'd1};
    tbl[7]  = '{4'b0001, 5'd0,  10'd0,    10'd0,    2'd0, 4'd0, 1'b1, 5'd1};
    tbl[8]  = '{4'b1000, 5'd16, 10'd1023, 10'd1023, 2'd3, 4'd0, 1'b1, 5'd16};
    tbl[9]  = '{4'b0110, 5'd0,  10'd0,    10'd1,    2'd1, 4'd0, 1'b0, 5'd1};
    tbl[10] = '{4'b0011, 5'd0,  10'd0,    10'd1000, 2'd0, 4'd9, 1'b0, 5'd1};
    tbl[11] = '{4'b0100, 5'd1,  10'd1001, 10'd1,    2'd2, 4'd0, 1'b0, 5'd2};
    tbl[12] = '{4'b0001, 5'd15, 10'd1023, 10'd500,  2'd0, 4'd9, 1'b0, 5'd16};

    repeat (3) @(negedge clk);
    check("reset outputs", 32'({ack, rsp_valid, rsp_value, rsp_err, rsp_id, busy, rng_step}), 32'd0);
    check("reset count", 32'(draw_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no step", 32'(rng_step), 32'd0);

    for (int i = 0; i < 13; i++) begin
      fill(int'(tbl[i].nrep), tbl[i].rep, tbl[i].tail);
      run_draw($sformatf("vec%0d", i), tbl[i].rq, int'(tbl[i].id),
               int'(tbl[i].val), int'(tbl[i].err), int'(tbl[i].steps));
    end

    // Reset during SAMPLE: everything clears at once and no ack follows.
    fill(16, 10'd1023, 10'd1023);
    @(negedge clk);
    req = 4'b0001;
    rng_raw = 10'd1023;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 32'(rng_step), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset outputs", 32'({ack, rsp_valid, rsp_value, rsp_err, rsp_id, busy, rng_step}), 32'd0);
    check("midreset count", 32'(draw_count), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    dc_m  = 0;
    fill(0, 10'd0, 10'd7);
    run_draw("post-reset", 4'b0100, 2, 6, 0, 1);

    // Randomized draws against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      rq = 4'($urandom_range(1, 15));
      for (int i = 0; i < MAXT; i++) begin
        int sel = $urandom_range(0, 19);
        if (n % 15 == 14)  raws[i] = 10'($urandom_range(1001, 1023));
        else if (sel == 0) raws[i] = 10'd0;
        else if (sel < 9)  raws[i] = 10'($urandom_range(1001, 1023));
        else               raws[i] = 10'($urandom_range(1, 1000));
      end
      e_id = winner(rq, ptr_m);
      e_val = 0; e_err = 1; e_steps = MAXT; done = 0;
      for (int i = 0; i < MAXT && !done; i++) begin
        if (raws[i] == 10'd0) begin
          e_err = 1; e_val = 0; e_steps = i + 1; done = 1;
        end else if (raws[i] <= 10'd1000) begin
          e_err = 0; e_val = (int'(raws[i]) - 1) % 10; e_steps = i + 1; done = 1;
        end
      end
      run_draw($sformatf("rnd%0d", n), rq, e_id, e_val, e_err, e_steps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
